// File: rtl/target_centroid.sv
// target_centroid: accumulates the coordinate sums and the hit count of the target
// pixels in a raster frame. At frame end it divides each sum by the count with two
// restoring dividers that run in parallel. The integer centroid is presented with a
// one-cycle o_Valid strobe, or an o_Lost strobe when the frame has too few hits.
module target_centroid #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int MIN_PIXELS = 16,
    parameter int ACC_W      = 28,
    parameter int CNT_W      = 19
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_Pixel_Valid,
    input  logic        i_Frame_Start,
    input  logic        i_Pixel_Hit,
    output logic [15:0] o_Z_X,
    output logic [15:0] o_Z_Y,
    output logic        o_Valid,
    output logic        o_Lost,
    output logic        o_Busy
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IW = $clog2(ACC_W + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic {IDLE, ACCUM} acc_state_t;
    typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_t;

    // ---------------- accumulator side ----------------
    acc_state_t       acc_state_q, acc_state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [ACC_W-1:0] sum_x_q, sum_x_d;
    logic [ACC_W-1:0] sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A frame-start pixel is processed as (0,0) whatever the counters say
    logic [XW-1:0]    pos_x;
    logic [YW-1:0]    pos_y;
    logic             at_end;
    logic [ACC_W-1:0] add_x, add_y, snap_x, snap_y;
    logic [CNT_W-1:0] add_c, snap_c;
    logic             snap_valid, snap_low;

    assign pos_x      = i_Frame_Start ? '0 : x_q;
    assign pos_y      = i_Frame_Start ? '0 : y_q;
    assign at_end     = (pos_x == X_LAST) && (pos_y == Y_LAST);
    assign add_x      = i_Pixel_Hit ? ACC_W'(pos_x) : '0;
    assign add_y      = i_Pixel_Hit ? ACC_W'(pos_y) : '0;
    assign add_c      = CNT_W'(i_Pixel_Hit);
    assign snap_x     = sum_x_q + add_x;
    assign snap_y     = sum_y_q + add_y;
    assign snap_c     = cnt_q + add_c;
    // Frame start wins over frame end, so a frame-start pixel never snapshots
    assign snap_valid = i_Pixel_Valid && !i_Frame_Start && (acc_state_q == ACCUM) && at_end;
    assign snap_low   = snap_valid && (snap_c < CNT_W'(MIN_PIXELS));

    // Next-state logic for the raster counters, the accumulators and the IDLE/ACCUM FSM
    always_comb begin
        acc_state_d = acc_state_q;
        x_d         = x_q;
        y_d         = y_q;
        sum_x_d     = sum_x_q;
        sum_y_d     = sum_y_q;
        cnt_d       = cnt_q;
        if (i_Pixel_Valid) begin
            if (pos_x == X_LAST) begin
                x_d = '0;
                y_d = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
            end else begin
                x_d = pos_x + XW'(1);
                y_d = pos_y;
            end
            if (i_Frame_Start) begin
                acc_state_d = ACCUM;
                sum_x_d     = add_x;
                sum_y_d     = add_y;
                cnt_d       = add_c;
            end else if (acc_state_q == ACCUM) begin
                if (at_end) begin
                    acc_state_d = IDLE;
                    sum_x_d     = '0;
                    sum_y_d     = '0;
                    cnt_d       = '0;
                end else begin
                    sum_x_d = snap_x;
                    sum_y_d = snap_y;
                    cnt_d   = snap_c;
                end
            end
        end
    end

    // Accumulator state register
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            acc_state_q <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            cnt_q       <= '0;
        end else begin
            acc_state_q <= acc_state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            cnt_q       <= cnt_d;
        end
    end

    // ---------------- divider side ----------------
    // Lane 0 divides sum_x, lane 1 divides sum_y. The quotient register starts
    // holding the dividend and shifts quotient bits in from the bottom.
    div_state_t       div_state_q, div_state_d;
    logic [IW-1:0]    it_q, it_d;
    logic [CNT_W-1:0] divisor_q, divisor_d;
    logic [ACC_W-1:0] quo_q [2];
    logic [ACC_W-1:0] quo_d [2];
    logic [ACC_W-2:0] rem_q [2];
    logic [ACC_W-2:0] rem_d [2];
    logic [15:0]      z_x_q, z_x_d, z_y_q, z_y_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;
    logic             lost_arm_q, lost_arm_d;

    // The remainder stays below the divisor, so ACC_W-1 bits are enough for it
    // and for the difference taken when the trial value is large enough.
    logic [ACC_W-2:0] div_ext;
    logic [ACC_W-1:0] trial    [2];
    logic [ACC_W-2:0] diff     [2];
    logic             ge       [2];
    logic [ACC_W-2:0] rem_step [2];
    logic [ACC_W-1:0] quo_step [2];

    assign div_ext = (ACC_W - 1)'(divisor_q);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign trial[gi]    = {rem_q[gi], quo_q[gi][ACC_W-1]};
            assign ge[gi]       = trial[gi] >= {1'b0, div_ext};
            assign diff[gi]     = trial[gi][ACC_W-2:0] - div_ext;
            assign rem_step[gi] = ge[gi] ? diff[gi] : trial[gi][ACC_W-2:0];
            assign quo_step[gi] = {quo_q[gi][ACC_W-2:0], ge[gi]};
        end
    endgenerate

    // Divider FSM next state; a snapshot overrides whatever the divider was doing
    always_comb begin
        div_state_d = div_state_q;
        it_d        = it_q;
        divisor_d   = divisor_q;
        z_x_d       = z_x_q;
        z_y_d       = z_y_q;
        valid_d     = 1'b0;
        lost_d      = 1'b0;
        lost_arm_d  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            quo_d[i] = quo_q[i];
            rem_d[i] = rem_q[i];
        end
        case (div_state_q)
            D_RUN: begin
                for (int i = 0; i < 2; i++) begin
                    quo_d[i] = quo_step[i];
                    rem_d[i] = rem_step[i];
                end
                it_d = it_q + IW'(1);
                if (it_q == IW'(ACC_W - 1)) div_state_d = D_DONE;
            end
            D_DONE: begin
                z_x_d       = quo_q[0][15:0];
                z_y_d       = quo_q[1][15:0];
                valid_d     = 1'b1;
                div_state_d = D_IDLE;
            end
            default: ;
        endcase
        if (snap_valid) begin
            if (snap_low) begin
                div_state_d = D_IDLE;
            end else begin
                div_state_d = D_RUN;
                it_d        = '0;
                divisor_d   = snap_c;
                quo_d[0]    = snap_x;
                quo_d[1]    = snap_y;
                rem_d[0]    = '0;
                rem_d[1]    = '0;
            end
        end
        // Lost fires one edge after the snapshot; if that edge also issues a
        // valid strobe it is held back one more cycle so the two never overlap.
        if (div_state_q == D_DONE) begin
            lost_arm_d = snap_low || lost_arm_q;
        end else begin
            lost_arm_d = snap_low;
            lost_d     = lost_arm_q;
        end
    end

    // Divider state register and output registers
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            div_state_q <= D_IDLE;
            it_q        <= '0;
            divisor_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                quo_q[i] <= '0;
                rem_q[i] <= '0;
            end
            z_x_q       <= '0;
            z_y_q       <= '0;
            valid_q     <= 1'b0;
            lost_q      <= 1'b0;
            lost_arm_q  <= 1'b0;
        end else begin
            div_state_q <= div_state_d;
            it_q        <= it_d;
            divisor_q   <= divisor_d;
            for (int i = 0; i < 2; i++) begin
                quo_q[i] <= quo_d[i];
                rem_q[i] <= rem_d[i];
            end
            z_x_q       <= z_x_d;
            z_y_q       <= z_y_d;
            valid_q     <= valid_d;
            lost_q      <= lost_d;
            lost_arm_q  <= lost_arm_d;
        end
    end

    assign o_Z_X   = z_x_q;
    assign o_Z_Y   = z_y_q;
    assign o_Valid = valid_q;
    assign o_Lost  = lost_q;
    assign o_Busy  = (div_state_q == D_RUN);

endmodule

// File: tb/tb_target_centroid.sv
// Directed testbench for target_centroid on a reduced 32x24 raster.
module tb_target_centroid;

    localparam int W = 32;
    localparam int H = 24;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        pv    = 1'b0;
    logic        fs    = 1'b0;
    logic        hit   = 1'b0;
    logic [15:0] zx, zy;
    logic        vld, lost, busy;

    int cyc     = 0;
    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;
    int n_lost  = 0;
    int n_both  = 0;
    int e0      = 0;
    int lat;
    int v0, l0;

    target_centroid #(
        .IMG_W(W), .IMG_H(H), .MIN_PIXELS(16), .ACC_W(28), .CNT_W(19)
    ) dut (
        .i_Clk(clk), .i_Reset_n(rst_n),
        .i_Pixel_Valid(pv), .i_Frame_Start(fs), .i_Pixel_Hit(hit),
        .o_Z_X(zx), .o_Z_Y(zy), .o_Valid(vld), .o_Lost(lost), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe counters sampled away from the active edge
    always @(negedge clk) begin
        if (vld)         n_valid <= n_valid + 1;
        if (lost)        n_lost  <= n_lost + 1;
        if (vld && lost) n_both  <= n_both + 1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("  %s: got %0d ok", tag, act);
        end
    endtask

    // Sends npix pixels in raster order, hits inside the box up to maxh of them.
    // An occasional idle cycle exercises stalling. e0 = edge of the last pixel.
    task automatic send_frame(input int x0, input int x1, input int y0, input int y1,
                              input int maxh, input int npix, input bit use_fs);
        int nh = 0;
        for (int p = 0; p < npix; p++) begin
            int x = p % W;
            int y = p / W;
            if (p % 37 == 5) begin
                @(negedge clk);
                pv = 1'b0; fs = 1'b0; hit = 1'b0;
            end
            @(negedge clk);
            pv  = 1'b1;
            fs  = use_fs && (p == 0);
            hit = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1) && (nh < maxh);
            if (hit) nh++;
        end
        @(negedge clk);
        pv = 1'b0; fs = 1'b0; hit = 1'b0;
        e0 = cyc;
    endtask

    // Bounded wait for a strobe; l = edges after e0, or -1 on timeout
    task automatic wait_strobe(input bit want_lost, output int l);
        l = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (want_lost ? lost : vld) begin
                l = cyc - e0;
                break;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_zx", int'(zx), 0);
        chk("rst_zy", int'(zy), 0);
        chk("rst_valid", int'(vld), 0);
        chk("rst_lost", int'(lost), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4x4 block x=10..13, y=5..8: 184/16 = 11, 104/16 = 6
        send_frame(10, 13, 5, 8, 16, W * H, 1'b1);
        chk("busy_after_e0", int'(busy), 1);
        wait_strobe(1'b0, lat);
        chk("valid_latency", lat, 29);
        chk("blk_zx", int'(zx), 11);
        chk("blk_zy", int'(zy), 6);
        @(negedge clk);
        chk("valid_one_cycle", int'(vld), 0);
        chk("busy_done", int'(busy), 0);

        // 15 hits: lost at E0+1, outputs hold, no valid
        v0 = n_valid;
        send_frame(10, 13, 5, 8, 15, W * H, 1'b1);
        wait_strobe(1'b1, lat);
        chk("lost_latency", lat, 1);
        @(negedge clk);
        chk("lost_one_cycle", int'(lost), 0);
        repeat (40) @(negedge clk);
        chk("lost_no_valid", n_valid, v0);
        chk("lost_hold_zx", int'(zx), 11);
        chk("lost_hold_zy", int'(zy), 6);

        // Partial frame of 20 hits on row 5, then a restart with a block at
        // x=20..23, y=10..13: 344/16 = 21, 184/16 = 11
        v0 = n_valid;
        send_frame(5, 24, 5, 5, 20, 6 * W, 1'b1);
        send_frame(20, 23, 10, 13, 16, W * H, 1'b1);
        wait_strobe(1'b0, lat);
        chk("restart_latency", lat, 29);
        chk("restart_zx", int'(zx), 21);
        chk("restart_zy", int'(zy), 11);
        repeat (3) @(negedge clk);
        chk("restart_one_valid", n_valid, v0 + 1);

        // Every pixel a hit: means 15.5 and 11.5 truncate to 15 and 11
        send_frame(0, W - 1, 0, H - 1, W * H, W * H, 1'b1);
        wait_strobe(1'b0, lat);
        chk("full_latency", lat, 29);
        chk("full_zx", int'(zx), 15);
        chk("full_zy", int'(zy), 11);

        // Asynchronous reset while the divider runs
        send_frame(10, 13, 5, 8, 16, W * H, 1'b1);
        repeat (5) @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_zx", int'(zx), 0);
        chk("async_zy", int'(zy), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_valid", int'(vld), 0);
        chk("async_lost", int'(lost), 0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        l0 = n_lost;
        repeat (40) @(negedge clk);
        chk("rst_no_valid", n_valid, v0);

        // Full hit frame without a frame start: must be ignored
        send_frame(0, W - 1, 0, H - 1, W * H, W * H, 1'b0);
        repeat (40) @(negedge clk);
        chk("nofs_no_valid", n_valid, v0);
        chk("nofs_no_lost", n_lost, l0);
        chk("nofs_zx", int'(zx), 0);

        // Recovery once a frame start arrives
        send_frame(10, 13, 5, 8, 16, W * H, 1'b1);
        wait_strobe(1'b0, lat);
        chk("recover_latency", lat, 29);
        chk("recover_zx", int'(zx), 11);
        chk("recover_zy", int'(zy), 6);

        repeat (3) @(negedge clk);
        chk("valid_lost_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
